// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its control sequencer: operation codes,
// opcodes, instruction field positions, sequencer states and operand selects.
package alu_pkg;

    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_AND  = 6'd3;
    localparam logic [5:0] ALU_OR   = 6'd4;
    localparam logic [5:0] ALU_XOR  = 6'd5;
    localparam logic [5:0] ALU_SLL  = 6'd6;
    localparam logic [5:0] ALU_SRL  = 6'd7;
    localparam logic [5:0] ALU_SRA  = 6'd8;
    localparam logic [5:0] ALU_ROL  = 6'd9;
    localparam logic [5:0] ALU_ROR  = 6'd10;
    localparam logic [5:0] ALU_SLT  = 6'd11;
    localparam logic [5:0] ALU_SGT  = 6'd12;
    localparam logic [5:0] ALU_SLE  = 6'd13;
    localparam logic [5:0] ALU_SGE  = 6'd14;
    localparam logic [5:0] ALU_SEQ  = 6'd15;
    localparam logic [5:0] ALU_SNE  = 6'd16;
    localparam logic [5:0] ALU_SLTU = 6'd17;
    localparam logic [5:0] ALU_SGTU = 6'd18;
    localparam logic [5:0] ALU_BNEZ = 6'd19;
    localparam logic [5:0] ALU_BEQZ = 6'd20;
    localparam logic [5:0] ALU_JR   = 6'd21;
    localparam logic [5:0] ALU_JALR = 6'd22;
    localparam logic [5:0] ALU_LHI  = 6'd23;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BNEZ  = 6'd19;
    localparam logic [5:0] OP_BEQZ  = 6'd20;
    localparam logic [5:0] OP_JR    = 6'd21;
    localparam logic [5:0] OP_JALR  = 6'd22;
    localparam logic [5:0] OP_LHI   = 6'd23;

    localparam int OP_LSB    = 26;
    localparam int RS1_LSB   = 21;
    localparam int RS2_LSB   = 16;
    localparam int RD_R_LSB  = 11;
    localparam int SH_R_LSB  = 6;
    localparam int SH_I_LSB  = 0;
    localparam int FUNCT_LSB = 0;

    localparam logic [4:0] LINK_REG = 5'd31;

    localparam logic [1:0] SRC_RS1 = 2'd0;
    localparam logic [1:0] SRC_PC  = 2'd1;
    localparam logic [1:0] SRC_ACC = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_EXEC, ST_WB, ST_ILLEGAL
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_SHIFT, CLS_BRANCH, CLS_JR, CLS_JALR, CLS_LHI
    } instr_class_t;

    function automatic logic is_shift(input logic [5:0] code);
        return (code >= ALU_SLL) && (code <= ALU_ROR);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder: splits a 32-bit instruction into ALU code,
// instruction class, register addresses, shift amount and immediate.
module alu_decode
    import alu_pkg::*;
#(
    parameter int SHAMT_W = 5
) (
    input  logic [31:0]        instr,
    output logic [5:0]         code,
    output instr_class_t       cls,
    output logic               rtype,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [SHAMT_W-1:0] shamt,
    output logic [31:0]        imm_sx,
    output logic               legal
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op     = instr[OP_LSB +: 6];
    assign funct  = instr[FUNCT_LSB +: 6];
    assign rs1    = instr[RS1_LSB +: 5];
    assign rs2    = instr[RS2_LSB +: 5];
    assign rtype  = (op == OP_RTYPE);
    assign imm_sx = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        code  = '0;
        cls   = CLS_ALU;
        rd    = '0;
        shamt = '0;
        legal = 1'b0;
        if (op == OP_RTYPE) begin
            if (funct != 6'd0 && funct <= ALU_SGTU) begin
                legal = 1'b1;
                code  = funct;
                rd    = instr[RD_R_LSB +: 5];
                shamt = instr[SH_R_LSB +: SHAMT_W];
                cls   = is_shift(funct) ? CLS_SHIFT : CLS_ALU;
            end
        end else if (op <= ALU_SGTU) begin
            legal = 1'b1;
            code  = op;
            rd    = instr[RS2_LSB +: 5];
            shamt = instr[SH_I_LSB +: SHAMT_W];
            cls   = is_shift(op) ? CLS_SHIFT : CLS_ALU;
        end else begin
            case (op)
                OP_BNEZ, OP_BEQZ: begin
                    legal = 1'b1;
                    code  = op;
                    cls   = CLS_BRANCH;
                end
                OP_JR: begin
                    legal = 1'b1;
                    code  = ALU_JR;
                    cls   = CLS_JR;
                end
                OP_JALR: begin
                    legal = 1'b1;
                    code  = ALU_JALR;
                    cls   = CLS_JALR;
                    rd    = LINK_REG;
                end
                OP_LHI: begin
                    legal = 1'b1;
                    code  = ALU_LHI;
                    cls   = CLS_LHI;
                    rd    = instr[RS2_LSB +: 5];
                end
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU control sequencer: accepts one instruction when idle, decodes
// it, iterates single-bit shift codes N times and steers datapath write enables.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        rs1_is0,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [5:0]  alu_ctrl,
    output logic [1:0]  src_a_sel,
    output logic        src_b_imm,
    output logic [31:0] imm_ext,
    output logic        acc_we,
    output logic        rf_we,
    output logic        wb_lhi,
    output logic        pc_we,
    output logic        done,
    output logic        illegal
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] CNT_TWO = SHAMT_W'(2);

    // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE, so the instruction is held until retirement.
    state_t             state, state_n;
    logic [31:0]        instr_q;
    logic [SHAMT_W-1:0] cnt, cnt_load;

    logic [5:0]         dec_code, eff_code;
    instr_class_t       dec_cls;
    logic               dec_rtype, dec_legal, shift_copy, branch_taken;
    logic [4:0]         dec_rs1, dec_rs2, dec_rd;
    logic [SHAMT_W-1:0] dec_shamt;
    logic [31:0]        dec_imm;

    alu_decode #(.SHAMT_W(SHAMT_W)) u_decode (
        .instr  (instr_q),
        .code   (dec_code),
        .cls    (dec_cls),
        .rtype  (dec_rtype),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .shamt  (dec_shamt),
        .imm_sx (dec_imm),
        .legal  (dec_legal)
    );

    // A zero-length shift degenerates into a single ADD of rs1 with zero.
    assign shift_copy   = (dec_cls == CLS_SHIFT) && (dec_shamt == '0);
    assign eff_code     = shift_copy ? ALU_ADD : dec_code;
    assign branch_taken = (dec_code == ALU_BEQZ) ? rs1_is0 : !rs1_is0;

    always_comb begin
        cnt_load = CNT_ONE;
        if (dec_cls == CLS_SHIFT && !shift_copy) cnt_load = dec_shamt;
        else if (dec_cls == CLS_JALR)            cnt_load = CNT_TWO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            instr_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && instr_valid) instr_q <= instr;
            if (state == ST_DECODE)                   cnt <= cnt_load;
            else if (state == ST_EXEC && cnt != CNT_ONE) cnt <= cnt - CNT_ONE;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (instr_valid) state_n = ST_DECODE;
            ST_DECODE:  state_n = dec_legal ? ST_EXEC : ST_ILLEGAL;
            ST_EXEC:    if (cnt == CNT_ONE) state_n = ST_WB;
            ST_WB:      state_n = ST_IDLE;
            ST_ILLEGAL: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    assign rs1_addr    = dec_rs1;
    assign rs2_addr    = dec_rs2;
    assign rd_addr     = dec_rd;
    assign imm_ext     = shift_copy ? 32'd0 : dec_imm;
    assign instr_ready = (state == ST_IDLE);

    always_comb begin
        alu_ctrl  = '0;
        src_a_sel = SRC_RS1;
        src_b_imm = 1'b0;
        acc_we    = 1'b0;
        rf_we     = 1'b0;
        wb_lhi    = 1'b0;
        pc_we     = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_DECODE: alu_ctrl = eff_code;
            ST_EXEC: begin
                alu_ctrl  = eff_code;
                src_b_imm = !dec_rtype || shift_copy;
                acc_we    = 1'b1;
                case (dec_cls)
                    CLS_SHIFT:
                        src_a_sel = (shift_copy || cnt == dec_shamt) ? SRC_RS1 : SRC_ACC;
                    CLS_BRANCH: begin
                        src_a_sel = SRC_PC;
                        acc_we    = 1'b0;
                        pc_we     = branch_taken;
                    end
                    CLS_JR: begin
                        acc_we = 1'b0;
                        pc_we  = 1'b1;
                    end
                    // First cycle captures the link address, second performs the jump.
                    CLS_JALR: begin
                        if (cnt == CNT_TWO) begin
                            src_a_sel = SRC_PC;
                        end else begin
                            acc_we = 1'b0;
                            pc_we  = 1'b1;
                        end
                    end
                    default: src_a_sel = SRC_RS1;
                endcase
            end
            ST_WB: begin
                alu_ctrl = eff_code;
                rf_we    = (dec_cls != CLS_BRANCH) && (dec_cls != CLS_JR);
                wb_lhi   = (dec_cls == CLS_LHI);
                done     = 1'b1;
            end
            ST_ILLEGAL: illegal = 1'b1;
            default: alu_ctrl = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: each instruction is traced cycle by cycle
// from DECODE to retirement and compared against hand-computed expectations.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        rs1_is0;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [5:0]  alu_ctrl;
    logic [1:0]  src_a_sel;
    logic        src_b_imm;
    logic [31:0] imm_ext;
    logic        acc_we, rf_we, wb_lhi, pc_we, done, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl #(.SHAMT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rs1_is0     (rs1_is0),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .alu_ctrl    (alu_ctrl),
        .src_a_sel   (src_a_sel),
        .src_b_imm   (src_b_imm),
        .imm_ext     (imm_ext),
        .acc_we      (acc_we),
        .rf_we       (rf_we),
        .wb_lhi      (wb_lhi),
        .pc_we       (pc_we),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // per-cycle trace, index 1 = DECODE cycle
    logic [5:0]  t_alu   [0:63];
    logic [1:0]  t_src_a [0:63];
    logic        t_src_b [0:63];
    logic        t_acc   [0:63];
    logic        t_pc    [0:63];
    logic        t_rf    [0:63];
    logic [31:0] t_imm   [0:63];
    logic [4:0]  t_rd    [0:63];
    logic [4:0]  t_rs1   [0:63];
    logic [4:0]  t_rs2   [0:63];
    int t_len, t_ill, rf_cnt, pc_cnt, acc_cnt, busy_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_instr(input logic [5:0] funct, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [4:0] rd,
                                            input logic [4:0] shamt);
        return {6'd0, rs1, rs2, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [4:0] rs1,
                                            input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs1, rd, imm};
    endfunction

    // Offers one instruction, then records every cycle until done or illegal.
    task automatic run_instr(input logic [31:0] ins, input logic rs1z);
        int g;
        logic found;
        rs1_is0     = rs1z;
        instr       = ins;
        instr_valid = 1'b1;
        g = 0;
        while (!instr_ready && g < 50) begin
            step();
            g++;
        end
        check("ready_wait", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        instr       = '0;
        found = 1'b0;
        t_len = 0; t_ill = 0; rf_cnt = 0; pc_cnt = 0; acc_cnt = 0; busy_ready = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            t_alu[k] = alu_ctrl;  t_src_a[k] = src_a_sel; t_src_b[k] = src_b_imm;
            t_acc[k] = acc_we;    t_pc[k]    = pc_we;     t_rf[k]    = rf_we;
            t_imm[k] = imm_ext;   t_rd[k]    = rd_addr;
            t_rs1[k] = rs1_addr;  t_rs2[k]   = rs2_addr;
            rf_cnt  += int'(rf_we);
            pc_cnt  += int'(pc_we);
            acc_cnt += int'(acc_we);
            busy_ready += int'(instr_ready);
            if (done || illegal) begin
                found = 1'b1;
                t_len = k;
                t_ill = int'(illegal);
            end else begin
                step();
            end
        end
        check("trace_end", 32'(found), 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; rs1_is0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   32'(instr_ready), 32'd1);
        check("rst_alu",     32'(alu_ctrl),    32'd0);
        check("rst_enables", 32'({acc_we, rf_we, wb_lhi, pc_we, done, illegal}), 32'd0);
        check("rst_imm",     imm_ext,          32'd0);
        check("rst_addr",    32'({rs1_addr, rs2_addr, rd_addr}), 32'd0);
        rst = 1'b0;
        step();

        // R-type ADD
        run_instr(r_instr(6'd1, 5'd3, 5'd4, 5'd5, 5'd0), 1'b0);
        check("add_len",   32'(t_len),      32'd3);
        check("add_dec",   32'(t_alu[1]),   32'd1);
        check("add_rs",    32'({t_rs1[1], t_rs2[1]}), 32'({5'd3, 5'd4}));
        check("add_exec",  32'({t_alu[2], t_src_a[2], t_src_b[2], t_acc[2]}), 32'({6'd1, 2'd0, 1'b0, 1'b1}));
        check("add_wb",    32'({t_rf[3], t_rd[3]}), 32'({1'b1, 5'd5}));
        check("add_cnts",  32'({8'(rf_cnt), 8'(pc_cnt), 8'(busy_ready)}), 32'h010000);

        // RI SLL by 4
        run_instr(i_instr(6'd6, 5'd2, 5'd7, 16'h0004), 1'b0);
        check("sll_len",   32'(t_len), 32'd6);
        check("sll_srca",  32'({t_src_a[2], t_src_a[3], t_src_a[4], t_src_a[5]}), 32'b00_10_10_10);
        check("sll_alu",   32'({t_alu[2], t_alu[3], t_alu[4], t_alu[5]}), 32'({6'd6, 6'd6, 6'd6, 6'd6}));
        check("sll_srcb",  32'(t_src_b[2]), 32'd1);
        check("sll_cnts",  32'({8'(acc_cnt), 8'(rf_cnt), 8'(pc_cnt)}), 32'h040100);
        check("sll_wb",    32'({t_rf[6], t_rd[6]}), 32'({1'b1, 5'd7}));

        // R-type SLL by 0 becomes an ADD copy of rs1
        run_instr(r_instr(6'd6, 5'd1, 5'd2, 5'd9, 5'd0), 1'b0);
        check("copy_len",  32'(t_len), 32'd3);
        check("copy_exec", 32'({t_alu[2], t_src_a[2], t_src_b[2]}), 32'({6'd1, 2'd0, 1'b1}));
        check("copy_imm",  t_imm[2], 32'd0);
        check("copy_wb",   32'({t_rf[3], t_rd[3]}), 32'({1'b1, 5'd9}));

        // BEQZ taken
        run_instr(i_instr(6'd20, 5'd4, 5'd0, 16'h0010), 1'b1);
        check("beqz_len",  32'(t_len), 32'd3);
        check("beqz_exec", 32'({t_alu[2], t_src_a[2], t_src_b[2], t_pc[2]}), 32'({6'd20, 2'd1, 1'b1, 1'b1}));
        check("beqz_imm",  t_imm[2], 32'h10);
        check("beqz_cnts", 32'({8'(rf_cnt), 8'(pc_cnt)}), 32'h0001);

        // JALR: link capture then jump
        run_instr(i_instr(6'd22, 5'd6, 5'd0, 16'h0000), 1'b0);
        check("jalr_len",  32'(t_len), 32'd4);
        check("jalr_c1",   32'({t_src_a[2], t_acc[2], t_pc[2]}), 32'({2'd1, 1'b1, 1'b0}));
        check("jalr_c2",   32'({t_src_a[3], t_acc[3], t_pc[3]}), 32'({2'd0, 1'b0, 1'b1}));
        check("jalr_wb",   32'({t_rf[4], t_rd[4], t_alu[4]}), 32'({1'b1, 5'd31, 6'd22}));

        // LHI writes imm<<16 in WB
        run_instr(i_instr(6'd23, 5'd0, 5'd12, 16'hBEEF), 1'b0);
        check("lhi_wb",    32'({t_len[3:0], t_rf[3], t_rd[3], t_alu[3]}), 32'({4'd3, 1'b1, 5'd12, 6'd23}));

        // Illegal opcode and illegal funct
        run_instr(i_instr(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b0);
        check("ill_op",    32'({8'(t_len), 8'(t_ill), 8'(rf_cnt), 8'(pc_cnt)}), 32'h02010000);
        check("ill_op_rdy", 32'(instr_ready), 32'd1);
        run_instr(r_instr(6'h13, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0);
        check("ill_fn",    32'({8'(t_len), 8'(t_ill), 8'(rf_cnt), 8'(pc_cnt)}), 32'h02010000);
        check("ill_fn_rdy", 32'(instr_ready), 32'd1);

        // Back-to-back with instr_valid held high
        instr_valid = 1'b1;
        instr = r_instr(6'd1, 5'd1, 5'd2, 5'd3, 5'd0);
        step();
        instr = i_instr(6'd3, 5'd7, 5'd8, 16'h00FF);
        busy_ready = 0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            busy_ready += int'(instr_ready);
            if (done) seen = 1;
            else step();
        end
        check("b2b_done",   32'(seen), 32'd1);
        check("b2b_busy",   32'(busy_ready), 32'd0);
        step();
        check("b2b_idle",   32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        check("b2b_second", 32'({rs1_addr, alu_ctrl, instr_ready}), 32'({5'd7, 6'd3, 1'b0}));
        step();
        step();
        check("b2b_done2",  32'({done, rf_we, rd_addr}), 32'({1'b1, 1'b1, 5'd8}));
        step();

        // Async reset in the middle of an 8-step shift
        run_instr(i_instr(6'd0, 5'd0, 5'd0, 16'h0000), 1'b0);
        instr_valid = 1'b1;
        instr = i_instr(6'd7, 5'd3, 5'd4, 16'h0008);
        step();
        instr_valid = 1'b0;
        step(); step(); step();
        check("pre_rst_acc", 32'({acc_we, alu_ctrl}), 32'({1'b1, 6'd7}));
        rst = 1'b1;
        #1;
        check("rst_mid_out", 32'({alu_ctrl, acc_we, rf_we, pc_we, done, illegal}), 32'd0);
        check("rst_mid_rdy", 32'(instr_ready), 32'd1);
        step();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            seen += int'(done) + int'(acc_we) + int'(rf_we);
            step();
        end
        check("rst_no_done", 32'(seen), 32'd0);
        run_instr(r_instr(6'd2, 5'd10, 5'd11, 5'd12, 5'd0), 1'b0);
        check("post_rst",  32'({8'(t_len), t_alu[2], t_rd[3], t_rf[3]}), 32'({8'd3, 6'd2, 5'd12, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
